// File: rtl/gem_trig_tx_framer.sv
// Trigger-link framer: turns each held pair of 56-bit cluster words into a 4-word frame
// per transceiver lane, with a K-code separator in word 0 carrying BX phase or TTC/overflow.
module gem_trig_tx_framer #(
    parameter int ALLOW_TTC_CHARS = 0,
    parameter int FRAME_CTRL_TTC  = 1,
    parameter int SYNC_STAGES     = 2
) (
    input  logic         clock_160,
    input  logic         reset_i,
    input  logic         ready_i,
    input  logic [111:0] gem_data,
    input  logic         overflow_i,
    input  logic         bc0_i,
    input  logic         resync_i,
    input  logic [1:0]   bxn_counter_lsbs,
    output logic         rd_en_o,
    output logic         ready_sync_o,
    output logic [63:0]  trg_tx_data,
    output logic [7:0]   trg_tx_isk
);

    localparam logic [1:0] FRAME_W0 = 2'd0;
    localparam logic [1:0] FRAME_W1 = 2'd1;
    localparam logic [1:0] FRAME_W2 = 2'd2;
    localparam logic [1:0] FRAME_W3 = 2'd3;

    localparam logic [15:0] IDLE_WORD = 16'hFFFC;
    localparam logic [1:0]  IDLE_ISK  = 2'b01;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   run;
    logic [1:0]             tx_frame;
    logic [3:0]             sep_cnt;

    logic [116:0] hold_q;
    logic         hold_load;
    logic [55:0]  hold_a;
    logic [55:0]  hold_b;
    logic         hold_bc0;
    logic         hold_resync;
    logic         hold_overflow;
    logic [1:0]   hold_bxn;

    logic [1:0]   sep_sel;
    logic [7:0]   sep;
    logic [15:0]  word_a;
    logic [15:0]  word_b;

    always_ff @(posedge clock_160 or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ready_i};
        end
    end

    assign ready_sync_o = sync_q[SYNC_STAGES-1];
    assign run          = ready_sync_o;

    always_ff @(posedge clock_160 or posedge reset_i) begin
        if (reset_i) begin
            tx_frame <= FRAME_W0;
            sep_cnt  <= '0;
        end else if (!run) begin
            tx_frame <= FRAME_W0;
            sep_cnt  <= '0;
        end else begin
            tx_frame <= tx_frame + 2'd1;
            sep_cnt  <= sep_cnt + 4'd1;
        end
    end

    assign rd_en_o = run && (tx_frame == FRAME_W0);

    // Refilled on the last word so the next frame's word 0 already sees fresh FIFO data.
    assign hold_load = !run || (tx_frame == FRAME_W3);

    always_ff @(posedge clock_160 or posedge reset_i) begin
        if (reset_i) begin
            hold_q <= '0;
        end else if (hold_load) begin
            hold_q <= {gem_data, bc0_i, resync_i, overflow_i, bxn_counter_lsbs};
        end
    end

    assign hold_b        = hold_q[116:61];
    assign hold_a        = hold_q[60:5];
    assign hold_bc0      = hold_q[4];
    assign hold_resync   = hold_q[3];
    assign hold_overflow = hold_q[2];
    assign hold_bxn      = hold_q[1:0];

    always_comb begin
        sep_sel = (FRAME_CTRL_TTC != 0) ? hold_bxn : sep_cnt[3:2];
        case (sep_sel)
            2'd0:    sep = 8'hBC;
            2'd1:    sep = 8'hF7;
            2'd2:    sep = 8'hFB;
            default: sep = 8'hFD;
        endcase
        if (ALLOW_TTC_CHARS != 0) begin
            if (hold_bc0) begin
                sep = 8'h1C;
            end else if (hold_resync) begin
                sep = 8'h3C;
            end else if (hold_overflow) begin
                sep = 8'hFC;
            end
        end
    end

    function automatic logic [15:0] frame_word(input logic [55:0] p,
                                               input logic [1:0]  idx,
                                               input logic [7:0]  s);
        case (idx)
            FRAME_W0: frame_word = {p[7:0], s};
            FRAME_W1: frame_word = p[23:8];
            FRAME_W2: frame_word = p[39:24];
            default:  frame_word = p[55:40];
        endcase
    endfunction

    always_comb begin
        word_a = frame_word(hold_a, tx_frame, sep);
        word_b = frame_word(hold_b, tx_frame, sep);
    end

    always_ff @(posedge clock_160 or posedge reset_i) begin
        if (reset_i) begin
            trg_tx_data <= {4{IDLE_WORD}};
            trg_tx_isk  <= {4{IDLE_ISK}};
        end else if (!run) begin
            trg_tx_data <= {4{IDLE_WORD}};
            trg_tx_isk  <= {4{IDLE_ISK}};
        end else begin
            trg_tx_data <= {word_b, word_a, word_b, word_a};
            trg_tx_isk  <= (tx_frame == FRAME_W0) ? {4{2'b01}} : 8'h00;
        end
    end

endmodule

// File: tb/tb_gem_trig_tx_framer.sv
// Bench for gem_trig_tx_framer: two parameterisations driven from shared stimulus,
// a frame-level reference model checked every cycle, plus hand-computed spot checks.
module tb_gem_trig_tx_framer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ready = 1'b0;
    logic [111:0] gem = '0;
    logic         ovf = 1'b0;
    logic         bc0 = 1'b0;
    logic         rsy = 1'b0;
    logic [1:0]   bxn = 2'd0;

    logic         d0_rd, d0_rs, d1_rd, d1_rs;
    logic [63:0]  d0_data, d1_data;
    logic [7:0]   d0_isk, d1_isk;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gem_trig_tx_framer #(.ALLOW_TTC_CHARS(1), .FRAME_CTRL_TTC(0), .SYNC_STAGES(2)) dut0 (
        .clock_160(clk), .reset_i(rst), .ready_i(ready), .gem_data(gem),
        .overflow_i(ovf), .bc0_i(bc0), .resync_i(rsy), .bxn_counter_lsbs(bxn),
        .rd_en_o(d0_rd), .ready_sync_o(d0_rs), .trg_tx_data(d0_data), .trg_tx_isk(d0_isk)
    );

    gem_trig_tx_framer #(.ALLOW_TTC_CHARS(0), .FRAME_CTRL_TTC(1), .SYNC_STAGES(3)) dut1 (
        .clock_160(clk), .reset_i(rst), .ready_i(ready), .gem_data(gem),
        .overflow_i(ovf), .bc0_i(bc0), .resync_i(rsy), .bxn_counter_lsbs(bxn),
        .rd_en_o(d1_rd), .ready_sync_o(d1_rs), .trg_tx_data(d1_data), .trg_tx_isk(d1_isk)
    );

    localparam logic [63:0] IDLE_DATA = 64'hFFFC_FFFC_FFFC_FFFC;

    typedef struct packed {
        logic [111:0] gem;
        logic         bc0;
        logic         rsy;
        logic         ovf;
        logic [1:0]   bxn;
    } snap_t;

    snap_t       m_snap [2];
    logic [7:0]  m_hist [2];
    logic        m_run  [2];
    int unsigned m_len  [2];
    logic [63:0] e_data [2];
    logic [7:0]  e_isk  [2];
    logic        e_rd   [2];
    logic        e_rs   [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] sep_model(input snap_t s, input bit allow, input bit fct,
                                             input int unsigned frame);
        logic [1:0] sel;
        if (allow && s.bc0) return 8'h1C;
        if (allow && s.rsy) return 8'h3C;
        if (allow && s.ovf) return 8'hFC;
        sel = fct ? s.bxn : 2'(frame % 4);
        case (sel)
            2'd0:    return 8'hBC;
            2'd1:    return 8'hF7;
            2'd2:    return 8'hFB;
            default: return 8'hFD;
        endcase
    endfunction

    function automatic logic [15:0] word_of(input logic [55:0] p, input int unsigned w,
                                            input logic [7:0] s);
        case (w)
            0:       return {p[7:0], s};
            1:       return p[23:8];
            2:       return p[39:24];
            default: return p[55:40];
        endcase
    endfunction

    // m_len counts cycles spent running; word index and frame number follow from it.
    task automatic model_step(input int i, input bit allow, input bit fct, input int sync);
        snap_t       live;
        logic [7:0]  s;
        logic [15:0] wa, wb;
        int unsigned w;
        live.gem = gem; live.bc0 = bc0; live.rsy = rsy; live.ovf = ovf; live.bxn = bxn;
        if (rst) begin
            m_hist[i] = '0; m_run[i] = 1'b0; m_len[i] = 0; m_snap[i] = '0;
            e_data[i] = IDLE_DATA; e_isk[i] = 8'h55;
        end else begin
            if (m_run[i]) begin
                w  = m_len[i] % 4;
                s  = sep_model(m_snap[i], allow, fct, m_len[i] / 4);
                wa = word_of(m_snap[i].gem[55:0], w, s);
                wb = word_of(m_snap[i].gem[111:56], w, s);
                e_data[i] = {wb, wa, wb, wa};
                e_isk[i]  = (w == 0) ? 8'h55 : 8'h00;
                if (w == 3) m_snap[i] = live;
                m_len[i]++;
            end else begin
                e_data[i] = IDLE_DATA; e_isk[i] = 8'h55;
                m_snap[i] = live; m_len[i] = 0;
            end
            m_hist[i] = {m_hist[i][6:0], ready};
            m_run[i]  = m_hist[i][sync-1];
        end
        e_rs[i] = m_run[i];
        e_rd[i] = m_run[i] && (m_len[i] % 4 == 0);
    endtask

    always @(posedge clk) begin
        model_step(0, 1'b1, 1'b0, 2);
        model_step(1, 1'b0, 1'b1, 3);
        #1;
        chk("d0_ready_sync", d0_rs, e_rs[0]);
        chk("d0_rd_en", d0_rd, e_rd[0]);
        chk("d0_data", d0_data, e_data[0]);
        chk("d0_isk", d0_isk, e_isk[0]);
        chk("d1_ready_sync", d1_rs, e_rs[1]);
        chk("d1_rd_en", d1_rd, e_rd[1]);
        chk("d1_data", d1_data, e_data[1]);
        chk("d1_isk", d1_isk, e_isk[1]);
    end

    task automatic wait_rd(input int which, output int n);
        bit found;
        found = 0;
        n = 0;
        while (!found && n < 40) begin
            @(negedge clk);
            n++;
            if (((which == 0) ? d0_rd : d1_rd) === 1'b1) found = 1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_rd%0d: got no rd_en pulse, required one within 40 cycles", which);
        end
    endtask

    logic [7:0] bxn_seps [4];
    logic [7:0] flag_seps [3];
    logic [2:0] flag_set [3];

    initial begin
        int n;
        bxn_seps  = '{8'hBC, 8'hF7, 8'hFB, 8'hFD};
        flag_seps = '{8'h1C, 8'h3C, 8'hFC};
        flag_set  = '{3'b111, 3'b011, 3'b001};

        // Reset / idle
        repeat (3) @(negedge clk);
        chk("rst_data", d0_data, IDLE_DATA);
        chk("rst_isk", d0_isk, 8'h55);
        chk("rst_rd_en", d0_rd, 1'b0);
        chk("rst_ready_sync", d0_rs, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_data", d1_data, IDLE_DATA);
        chk("idle_rd_en", d1_rd, 1'b0);

        // Startup and payload mapping
        gem   = {56'hFEDCBA98765432, 56'h0123456789ABCD};
        ready = 1'b1;
        wait_rd(0, n);
        chk("startup_latency", n, 2);
        @(negedge clk);
        chk("pay_w0", d0_data, 64'h32BC_CDBC_32BC_CDBC);
        chk("pay_w0_isk", d0_isk, 8'h55);
        @(negedge clk);
        chk("pay_w1", d0_data, 64'h7654_89AB_7654_89AB);
        chk("pay_w1_isk", d0_isk, 8'h00);
        @(negedge clk);
        chk("pay_w2", d0_data, 64'hBA98_4567_BA98_4567);
        @(negedge clk);
        chk("pay_w3", d0_data, 64'hFEDC_0123_FEDC_0123);
        @(negedge clk);
        chk("pay_next_w0", d0_data, 64'h32F7_CDF7_32F7_CDF7);

        // Separator from bxn_counter_lsbs (dut1)
        for (int k = 0; k < 5; k++) begin
            wait_rd(1, n);
            if (k < 4) bxn = 2'(k);
            @(negedge clk);
            if (k > 0) chk("sep_bxn", d1_data[7:0], bxn_seps[k-1]);
        end

        // Flag priority (dut0); dut1 ignores flags
        for (int k = 0; k < 4; k++) begin
            wait_rd(0, n);
            if (k < 3) {bc0, rsy, ovf} = flag_set[k];
            else {bc0, rsy, ovf} = 3'b000;
            @(negedge clk);
            if (k > 0) chk("sep_flags", d0_data[7:0], flag_seps[k-1]);
        end

        // Ready loss at tx_frame=2, then restart
        wait_rd(0, n);
        @(negedge clk);
        @(negedge clk);
        ready = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_d0_data", d0_data, IDLE_DATA);
        chk("abort_d0_isk", d0_isk, 8'h55);
        chk("abort_d0_rd_en", d0_rd, 1'b0);
        chk("abort_d1_data", d1_data, IDLE_DATA);
        ready = 1'b1;
        wait_rd(0, n);
        chk("restart_latency", n, 2);
        @(negedge clk);
        chk("restart_w0", d0_data[15:0], 16'hCDBC);
        chk("restart_isk", d0_isk, 8'h55);

        // Asynchronous reset mid-frame
        wait_rd(0, n);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_data", d0_data, IDLE_DATA);
        chk("async_rst_isk", d0_isk, 8'h55);
        chk("async_rst_ready_sync", d0_rs, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_rd(0, n);
        chk("post_rst_latency", n, 2);
        @(negedge clk);
        chk("post_rst_w0", d0_data[15:0], 16'hCDBC);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
